mem_copy_dma: RTL and testbench
===============================

// Module: mem_copy_dma
// PURPOSE
//  Bus initiator for the single-port data memory: block copy (src->dst) or block fill
//  (constant pattern) on command, driving MEMread/MEMwrite/A/D and sampling rdata.
//  Sits between the CPU/debug command path and the data memory; frees the core from
//  word-by-word init/copy loops. Memory read is combinational, memory write commits on posedge clk.
// PARAMETERS
//  DATA_WIDTH  32  memory word width
//  BUS_WIDTH   10  memory address width (depth 2**BUS_WIDTH)
// PORTS
//  clk        in   1             system clock, all state on posedge
//  RST_n      in   1             asynchronous, active-low reset
//  start      in   1             command strobe, sampled in IDLE only
//  op         in   1             0 = copy, 1 = fill
//  src        in   BUS_WIDTH     copy source base address
//  dst        in   BUS_WIDTH     destination base address
//  len        in   BUS_WIDTH+1   word count, 0..2**BUS_WIDTH
//  pattern    in   DATA_WIDTH    fill value
//  abort      in   1             stop after current access
//  busy       out  1             high in any state other than IDLE
//  done       out  1             one-cycle pulse at end of command
//  aborted    out  1             valid with done: command was cut short
//  words_done out  BUS_WIDTH+1   words written by current/last command
//  MEMread    out  1             memory read enable
//  MEMwrite   out  1             memory write enable
//  A          out  BUS_WIDTH     memory address
//  D          out  DATA_WIDTH    memory write data
//  rdata      in   DATA_WIDTH    memory read data (combinational)
// BEHAVIOUR
//  Reset (RST_n=0, async): state=IDLE; busy, done, aborted, MEMread, MEMwrite = 0;
//   A, D, words_done = 0; internal pointers, count, buffer = 0. Reset mid-command
//   drops the command at once; no further strobes; a write in the reset cycle is lost.
//  FSM states: IDLE, RD, WR, DONE. Strobes/A/D are decoded from registered state only.
//  IDLE: start=1 at edge latches op, src, dst, len, pattern; clears words_done and aborted.
//   len==0 -> DONE; op=0 -> RD; op=1 -> WR. start in any other state is ignored.
//  RD (copy only): MEMread=1, A=src_ptr. At edge: buf<=rdata; src_ptr++; -> WR.
//  WR: MEMwrite=1, A=dst_ptr, D = op ? pattern : buf. At edge: dst_ptr++; words_done++;
//   remaining--. Then remaining==0 -> DONE, else copy -> RD, fill -> WR.
//  DONE: done=1 for exactly one cycle, busy=1; -> IDLE. busy low from next cycle.
//  abort sampled at the edge ending RD or WR: that access completes (a WR still commits
//   and counts), then -> DONE with aborted=1. abort in IDLE/DONE has no effect.
//   abort and last-word completion at the same edge: aborted=0.
//  Addresses wrap modulo 2**BUS_WIDTH (0x3FF+1 -> 0x000). len=2**BUS_WIDTH is legal.
//  Overlapping regions: strictly ascending, read-then-write per word; dst>src overlap
//   replicates source words by design (no memmove semantics).
//  Latency after the start edge: copy N words -> done in cycle 2N+1;
//   fill N words -> done in cycle N+1; len=0 -> done in cycle 1.
//  MEMread and MEMwrite are never high in the same cycle; both low in IDLE/DONE.
// TESTING
//  1 copy: preload RAM[0x010..0x013]=1,2,3,4; start op=0 src=0x010 dst=0x020 len=4
//    -> RAM[0x020..0x023]=1,2,3,4; done pulses cycle 9; words_done=4; aborted=0.
//  2 fill wrap: op=1 dst=0x3FE len=3 pattern=0xDEADBEEF -> RAM[0x3FE],[0x3FF],[0x000]
//    written; RAM[0x001] unchanged; done in cycle 4.
//  3 len=0: start -> done in cycle 1; MEMread=MEMwrite=0 throughout; words_done=0.
//  4 abort: copy len=8; abort=1 for one cycle in the 3rd WR -> exactly 3 words written;
//    done with aborted=1, words_done=3; start pulses while busy ignored.
//  5 reset mid-op: fill len=16; RST_n low for 1 cycle after 5 writes -> outputs 0
//    immediately; no further writes; a fresh start then runs normally.
//  6 overlap: RAM[0..3]=A,B,C,D; copy src=0 dst=1 len=3 -> RAM[1..3]=A,A,A.

Source files
------------

// File: rtl/mem_copy_dma_if.sv
// Memory-side bus between the copy/fill engine and the single-port data memory.
// The memory reads combinationally and commits writes on the rising clock edge.
interface mem_copy_dma_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 10
);
  logic                  MEMread;
  logic                  MEMwrite;
  logic [BUS_WIDTH-1:0]  A;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output MEMread,
    output MEMwrite,
    output A,
    output D,
    input  rdata
  );

  modport slave (
    input  MEMread,
    input  MEMwrite,
    input  A,
    input  D,
    output rdata
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Block copy / block fill engine for the single-port data memory.
// One word per RD+WR pair for copy, one word per WR for fill; strobes decode from state.
module mem_copy_dma #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  RST_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [BUS_WIDTH-1:0]  src,
  input  logic [BUS_WIDTH-1:0]  dst,
  input  logic [BUS_WIDTH:0]    len,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [BUS_WIDTH:0]    words_done,
  mem_copy_dma_if.master        mem
);

  localparam logic [BUS_WIDTH:0]   CntZero = '0;
  localparam logic [BUS_WIDTH:0]   CntOne  = {{BUS_WIDTH{1'b0}}, 1'b1};
  localparam logic [BUS_WIDTH-1:0] PtrOne  = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e                state_q, state_d;
  logic                  op_q, op_d;
  logic [BUS_WIDTH-1:0]  src_ptr_q, src_ptr_d;
  logic [BUS_WIDTH-1:0]  dst_ptr_q, dst_ptr_d;
  logic [BUS_WIDTH:0]    remaining_q, remaining_d;
  logic [BUS_WIDTH:0]    words_done_q, words_done_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  aborted_q, aborted_d;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= StIdle;
      op_q         <= 1'b0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      pattern_q    <= '0;
      buf_q        <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      remaining_q  <= remaining_d;
      words_done_q <= words_done_d;
      pattern_q    <= pattern_d;
      buf_q        <= buf_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    remaining_d  = remaining_q;
    words_done_d = words_done_q;
    pattern_d    = pattern_q;
    buf_d        = buf_q;
    aborted_d    = aborted_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d         = op;
          src_ptr_d    = src;
          dst_ptr_d    = dst;
          remaining_d  = len;
          pattern_d    = pattern;
          words_done_d = '0;
          aborted_d    = 1'b0;
          if (len == CntZero) begin
            state_d = StDone;
          end else if (op) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        buf_d     = mem.rdata;
        src_ptr_d = src_ptr_q + PtrOne;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else begin
          state_d = StWr;
        end
      end
      StWr: begin
        dst_ptr_d    = dst_ptr_q + PtrOne;
        words_done_d = words_done_q + CntOne;
        remaining_d  = remaining_q - CntOne;
        // Finishing the last word wins over a simultaneous abort.
        if (remaining_q == CntOne) begin
          state_d = StDone;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (op_q) begin
          state_d = StWr;
        end else begin
          state_d = StRd;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mem.MEMread  = 1'b0;
    mem.MEMwrite = 1'b0;
    mem.A        = '0;
    mem.D        = '0;
    case (state_q)
      StRd: begin
        mem.MEMread = 1'b1;
        mem.A       = src_ptr_q;
      end
      StWr: begin
        mem.MEMwrite = 1'b1;
        mem.A        = dst_ptr_q;
        mem.D        = op_q ? pattern_q : buf_q;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign aborted    = aborted_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma against a 1024x32 memory model with combinational read.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        RST_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [9:0]  src = '0;
  logic [9:0]  dst = '0;
  logic [10:0] len = '0;
  logic [31:0] pattern = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [10:0] words_done;

  logic [31:0] ram [1024];
  int          n_writes = 0;
  int          errors = 0;
  int          checks = 0;

  mem_copy_dma_if #(.DATA_WIDTH(32), .BUS_WIDTH(10)) mif ();

  mem_copy_dma #(.DATA_WIDTH(32), .BUS_WIDTH(10)) dut (
    .clk        (clk),
    .RST_n      (RST_n),
    .start      (start),
    .op         (op),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .pattern    (pattern),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .words_done (words_done),
    .mem        (mif.master)
  );

  always #5 clk = ~clk;

  assign mif.rdata = ram[mif.A];

  always @(posedge clk) begin
    if (mif.MEMwrite) begin
      ram[mif.A] = mif.D;
      n_writes   = n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic o, input logic [9:0] s, input logic [9:0] d,
                       input logic [10:0] l, input logic [31:0] p);
    @(negedge clk);
    op = o; src = s; dst = d; len = l; pattern = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the start edge until done; optional abort and ignored start pulses.
  task automatic wait_done(input int limit, input int abort_cyc, input int spur_cyc,
                           output int cyc, output logic strobe);
    cyc    = 0;
    strobe = 1'b0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      abort = (cyc == abort_cyc);
      if (cyc == spur_cyc) begin
        op = 1'b1; len = 11'd1; dst = 10'h3F0; pattern = 32'hFFFF_FFFF;
      end
      start  = (cyc == spur_cyc);
      strobe = strobe | mif.MEMread | mif.MEMwrite;
      if (mif.MEMread && mif.MEMwrite) check("rd_wr_exclusive", 32'd1, 32'd0);
      if (done) break;
    end
    abort = 1'b0;
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 32'(cyc), 32'(limit + 1));
      cyc = -1;
    end
  endtask

  initial begin
    int   cyc;
    logic strobe;
    int   nw0;

    for (int i = 0; i < 1024; i++) ram[i] = 32'hA5A5_0000 | 32'(i);

    // Reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_rd", 32'(mif.MEMread), 32'd0);
    check("rst_wr", 32'(mif.MEMwrite), 32'd0);
    check("rst_A", 32'(mif.A), 32'd0);
    check("rst_D", mif.D, 32'd0);
    check("rst_words", 32'(words_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    RST_n = 1'b1;

    // 1: copy 4 words
    ram[10'h010] = 32'd1; ram[10'h011] = 32'd2; ram[10'h012] = 32'd3; ram[10'h013] = 32'd4;
    issue(1'b0, 10'h010, 10'h020, 11'd4, 32'h0);
    wait_done(40, 0, 0, cyc, strobe);
    check("copy_cycle", 32'(cyc), 32'd9);
    check("copy_busy_at_done", 32'(busy), 32'd1);
    check("copy_words", 32'(words_done), 32'd4);
    check("copy_aborted", 32'(aborted), 32'd0);
    for (int i = 0; i < 4; i++) check("copy_data", ram[10'h020 + i], 32'(i + 1));
    @(negedge clk);
    check("copy_busy_after", 32'(busy), 32'd0);
    check("copy_done_after", 32'(done), 32'd0);

    // 2: fill across the top of memory
    ram[10'h001] = 32'h1111_1111;
    issue(1'b1, 10'h000, 10'h3FE, 11'd3, 32'hDEAD_BEEF);
    wait_done(40, 0, 0, cyc, strobe);
    check("fill_cycle", 32'(cyc), 32'd4);
    check("fill_3fe", ram[10'h3FE], 32'hDEAD_BEEF);
    check("fill_3ff", ram[10'h3FF], 32'hDEAD_BEEF);
    check("fill_000", ram[10'h000], 32'hDEAD_BEEF);
    check("fill_001_kept", ram[10'h001], 32'h1111_1111);
    check("fill_words", 32'(words_done), 32'd3);

    // 3: zero-length command
    issue(1'b0, 10'h050, 10'h060, 11'd0, 32'h0);
    wait_done(40, 0, 0, cyc, strobe);
    check("len0_cycle", 32'(cyc), 32'd1);
    check("len0_strobes", 32'(strobe), 32'd0);
    check("len0_words", 32'(words_done), 32'd0);

    // 4: abort during the third write, spurious start while busy
    for (int i = 0; i < 8; i++) ram[10'h040 + i] = 32'h100 + 32'(i);
    issue(1'b0, 10'h040, 10'h060, 11'd8, 32'h0);
    wait_done(40, 6, 2, cyc, strobe);
    check("abort_cycle", 32'(cyc), 32'd7);
    check("abort_flag", 32'(aborted), 32'd1);
    check("abort_words", 32'(words_done), 32'd3);
    check("abort_w0", ram[10'h060], 32'h100);
    check("abort_w1", ram[10'h061], 32'h101);
    check("abort_w2", ram[10'h062], 32'h102);
    check("abort_w3_kept", ram[10'h063], 32'hA5A5_0063);
    check("spur_start_ignored", ram[10'h3F0], 32'hA5A5_03F0);
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);

    // 5: reset in the middle of a 16-word fill
    nw0 = n_writes;
    issue(1'b1, 10'h000, 10'h100, 11'd16, 32'h55AA_55AA);
    repeat (5) @(posedge clk);
    @(negedge clk);
    RST_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr", 32'(mif.MEMwrite), 32'd0);
    check("midrst_A", 32'(mif.A), 32'd0);
    check("midrst_words", 32'(words_done), 32'd0);
    @(negedge clk);
    RST_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_nwrites", 32'(n_writes - nw0), 32'd5);
    check("midrst_104", ram[10'h104], 32'h55AA_55AA);
    check("midrst_105_kept", ram[10'h105], 32'hA5A5_0105);
    issue(1'b1, 10'h000, 10'h200, 11'd2, 32'h0BAD_F00D);
    wait_done(40, 0, 0, cyc, strobe);
    check("fresh_cycle", 32'(cyc), 32'd3);
    check("fresh_200", ram[10'h200], 32'h0BAD_F00D);
    check("fresh_201", ram[10'h201], 32'h0BAD_F00D);
    check("fresh_words", 32'(words_done), 32'd2);

    // 6: overlapping ascending copy replicates the first word
    ram[0] = 32'hA; ram[1] = 32'hB; ram[2] = 32'hC; ram[3] = 32'hD;
    issue(1'b0, 10'h000, 10'h001, 11'd3, 32'h0);
    wait_done(40, 0, 0, cyc, strobe);
    check("ovl_cycle", 32'(cyc), 32'd7);
    check("ovl_1", ram[1], 32'hA);
    check("ovl_2", ram[2], 32'hA);
    check("ovl_3", ram[3], 32'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
